// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared definitions for the boot loader, the program RAM and
//               the MAR: RAM geometry defaults and loader state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    localparam int c_ram_bytes = 16;
    localparam int c_addr_w    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_if
// Description : Host pin / RAM write / CPU control bundle of the boot loader.
//               master = host and RAM side, slave = loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = c_addr_w
) ();

    logic              load_req;
    logic [7:0]        byte_in;
    logic              byte_strobe;
    logic              byte_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_we;
    logic              cpu_run;
    logic              load_err;
    logic [ADDR_W:0]   byte_count;

    modport master (
        output load_req, byte_in, byte_strobe,
        input  byte_ready, ram_addr, ram_data, ram_we, cpu_run, load_err, byte_count
    );

    modport slave (
        input  load_req, byte_in, byte_strobe,
        output byte_ready, ram_addr, ram_data, ram_we, cpu_run, load_err, byte_count
    );

endinterface
`default_nettype wire

// File: rtl/program_loader_strobe_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : strobe_edge_detect
// Description : Rising-edge detector for the host byte strobe. The pulse is
//               high during the first cycle the strobe is sampled high after
//               a low sample; a held strobe yields a single pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic rise
);

    logic r_prev;

    // Remember the previous strobe sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= strobe;
        end
    end

    assign rise = strobe & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-time loader. Writes RAM_BYTES strobed program bytes into
//               program RAM, holds the CPU in reset until the image is
//               complete, then releases it. Build option LOADER_CHECKSUM_EN
//               adds a trailing checksum byte that must make the 8-bit sum of
//               the image zero before the CPU is released.
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int RAM_BYTES = c_ram_bytes,
    parameter int ADDR_W    = c_addr_w
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);

    localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(RAM_BYTES - 1);
    localparam logic [ADDR_W:0] c_one      = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_we;
    logic              r_run;
    logic              r_ready;
    logic [ADDR_W:0]   r_count;
    logic              w_rise;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_sum;
    logic              r_err;
    logic [7:0]        w_sum_next;

    assign w_sum_next = r_sum + bus.byte_in;
`endif

    strobe_edge_detect u_edge (
        .clk    (clk),
        .rst    (rst),
        .strobe (bus.byte_strobe),
        .rise   (w_rise)
    );

    // Loader FSM with address counter, checksum and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_run   <= 1'b0;
            r_ready <= 1'b0;
            r_count <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_we <= 1'b0;
            if (bus.load_req) begin
                // Restart wins over any strobe edge in the same cycle.
                r_state <= ST_LOAD;
                r_addr  <= '0;
                r_count <= '0;
                r_run   <= 1'b0;
                r_ready <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                r_sum   <= '0;
                r_err   <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_LOAD: begin
                        if (w_rise) begin
                            r_we    <= 1'b1;
                            r_data  <= bus.byte_in;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_count <= r_count + c_one;
`ifdef LOADER_CHECKSUM_EN
                            r_sum   <= w_sum_next;
                            if (r_count == c_last_idx) begin
                                r_state <= ST_CHECK;
                            end
`else
                            if (r_count == c_last_idx) begin
                                r_state <= ST_RUN;
                                r_run   <= 1'b1;
                                r_ready <= 1'b0;
                            end
`endif
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        // The checksum byte is compared only, never written.
                        if (w_rise) begin
                            r_ready <= 1'b0;
                            if (w_sum_next == 8'd0) begin
                                r_state <= ST_RUN;
                                r_run   <= 1'b1;
                            end else begin
                                r_state <= ST_ERROR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                    ST_ERROR: begin
                        r_state <= ST_ERROR;
                    end
`endif
                    ST_RUN: begin
                        r_state <= ST_RUN;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_run   <= 1'b0;
                        r_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ram_addr   = r_addr;
    assign bus.ram_data   = r_data;
    assign bus.ram_we     = r_we;
    assign bus.cpu_run    = r_run;
    assign bus.byte_ready = r_ready;
    assign bus.byte_count = r_count;
`ifdef LOADER_CHECKSUM_EN
    assign bus.load_err   = r_err;
`else
    assign bus.load_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. A write log and a
//               RAM image built from observed ram_we pulses are compared with
//               expectations derived from the byte stream sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW = 4;
    localparam int RB = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   wr_count;
    logic [7:0] ram_model [RB];

    program_loader_if #(.ADDR_W(AW)) bus ();

    program_loader #(.RAM_BYTES(RB), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe RAM writes away from the active edge.
    always @(negedge clk) begin
        if (bus.ram_we === 1'b1) begin
            wr_count = wr_count + 1;
            ram_model[bus.ram_addr] = bus.ram_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        tick();
    endtask

    task automatic strobe_byte(input logic [7:0] d, output logic we, output logic [AW-1:0] a,
                               output logic [7:0] dat, output logic [AW:0] cnt,
                               output logic run, output logic err);
        bus.byte_in     = d;
        bus.byte_strobe = 1'b1;
        tick();
        we  = bus.ram_we;
        a   = bus.ram_addr;
        dat = bus.ram_data;
        cnt = bus.byte_count;
        run = bus.cpu_run;
        err = bus.load_err;
        bus.byte_strobe = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.load_req = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        checks += 7;
        if (bus.cpu_run !== 1'b0)    begin errors++; $display("FAIL reset_cpu_run got %b want 0", bus.cpu_run); end
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready got %b want 0", bus.byte_ready); end
        if (bus.load_err !== 1'b0)   begin errors++; $display("FAIL reset_load_err got %b want 0", bus.load_err); end
        if (bus.ram_we !== 1'b0)     begin errors++; $display("FAIL reset_ram_we got %b want 0", bus.ram_we); end
        if (bus.ram_addr !== '0)     begin errors++; $display("FAIL reset_ram_addr got %h want 0", bus.ram_addr); end
        if (bus.ram_data !== '0)     begin errors++; $display("FAIL reset_ram_data got %h want 0", bus.ram_data); end
        if (bus.byte_count !== '0)   begin errors++; $display("FAIL reset_byte_count got %0d want 0", bus.byte_count); end
        bus.load_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_sequential();
        logic we, run, err, exp_run;
        logic [AW-1:0] a;
        logic [7:0] dat;
        logic [AW:0] cnt;
        int w0;
        start_load();
        checks++;
        if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL seq_ready got %b want 1", bus.byte_ready); end
        w0 = wr_count;
        for (int i = 0; i < RB; i++) begin
            strobe_byte(8'(i), we, a, dat, cnt, run, err);
`ifdef LOADER_CHECKSUM_EN
            exp_run = 1'b0;
`else
            exp_run = (i == RB - 1);
`endif
            checks += 5;
            if (we !== 1'b1)                 begin errors++; $display("FAIL seq_we[%0d] got %b want 1", i, we); end
            if (a !== AW'(i))                begin errors++; $display("FAIL seq_addr[%0d] got %0d want %0d", i, a, i); end
            if (dat !== 8'(i))               begin errors++; $display("FAIL seq_data[%0d] got %h want %h", i, dat, i); end
            if (cnt !== (AW+1)'(i + 1))      begin errors++; $display("FAIL seq_count[%0d] got %0d want %0d", i, cnt, i + 1); end
            if (run !== exp_run)             begin errors++; $display("FAIL seq_run[%0d] got %b want %b", i, run, exp_run); end
        end
`ifdef LOADER_CHECKSUM_EN
        strobe_byte(8'h88, we, a, dat, cnt, run, err);
        checks += 3;
        if (we !== 1'b0)  begin errors++; $display("FAIL seq_ck_we got %b want 0", we); end
        if (run !== 1'b1) begin errors++; $display("FAIL seq_ck_run got %b want 1", run); end
        if (err !== 1'b0) begin errors++; $display("FAIL seq_ck_err got %b want 0", err); end
`endif
        checks++;
        if (wr_count - w0 !== RB) begin errors++; $display("FAIL seq_writes got %0d want %0d", wr_count - w0, RB); end
    endtask

    task automatic test_checksum();
        logic we, run, err;
        logic [AW-1:0] a;
        logic [7:0] dat;
        logic [AW:0] cnt;
        int w0;
        // Reload from RUN: cpu_run must drop right after load_req is sampled.
        bus.load_req = 1'b1;
        tick();
        checks++;
        if (bus.cpu_run !== 1'b0) begin errors++; $display("FAIL reload_run_drop got %b want 0", bus.cpu_run); end
        bus.load_req = 1'b0;
        tick();
        for (int i = 0; i < RB; i++) strobe_byte(8'(i), we, a, dat, cnt, run, err);
        w0 = wr_count;
        strobe_byte(8'h89, we, a, dat, cnt, run, err);
        tick();
        checks += 4;
        if (we !== 1'b0)          begin errors++; $display("FAIL extra_we got %b want 0", we); end
        if (wr_count !== w0)      begin errors++; $display("FAIL extra_writes got %0d want %0d", wr_count, w0); end
        if (cnt !== (AW+1)'(RB))  begin errors++; $display("FAIL extra_count got %0d want %0d", cnt, RB); end
`ifdef LOADER_CHECKSUM_EN
        if (err !== 1'b1 || run !== 1'b0) begin errors++; $display("FAIL bad_ck got err=%b run=%b want err=1 run=0", err, run); end
`else
        if (err !== 1'b0 || run !== 1'b1) begin errors++; $display("FAIL run_hold got err=%b run=%b want err=0 run=1", err, run); end
`endif
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        checks += 3;
        if (bus.load_err !== 1'b0)   begin errors++; $display("FAIL restart_err got %b want 0", bus.load_err); end
        if (bus.byte_ready !== 1'b1) begin errors++; $display("FAIL restart_ready got %b want 1", bus.byte_ready); end
        if (bus.byte_count !== '0)   begin errors++; $display("FAIL restart_count got %0d want 0", bus.byte_count); end
        tick();
    endtask

    task automatic test_random();
        logic we, run, err, good, exp_run, exp_err;
        logic [AW-1:0] a;
        logic [7:0] dat, ck;
        logic [AW:0] cnt;
        logic [7:0] img [RB];
        int sum;
        for (int iter = 0; iter < 4; iter++) begin
            start_load();
            sum = 0;
            for (int i = 0; i < RB; i++) begin
                img[i] = 8'($urandom_range(0, 255));
                sum = (sum + img[i]) % 256;
            end
            for (int i = 0; i < RB; i++) begin
                strobe_byte(img[i], we, a, dat, cnt, run, err);
                checks += 2;
                if (we !== 1'b1 || a !== AW'(i)) begin errors++; $display("FAIL rnd_write[%0d] got we=%b addr=%0d want we=1 addr=%0d", i, we, a, i); end
                if (dat !== img[i])              begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, dat, img[i]); end
            end
            good = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            good = 1'($urandom_range(0, 1));
            ck = 8'((256 - sum) % 256);
            if (!good) ck = 8'(ck + 8'($urandom_range(1, 255)));
            strobe_byte(ck, we, a, dat, cnt, run, err);
            exp_run = good;
            exp_err = !good;
`else
            run = bus.cpu_run;
            err = bus.load_err;
            exp_run = 1'b1;
            exp_err = 1'b0;
`endif
            checks += 2;
            if (run !== exp_run) begin errors++; $display("FAIL rnd_run[%0d] got %b want %b", iter, run, exp_run); end
            if (err !== exp_err) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", iter, err, exp_err); end
            for (int i = 0; i < RB; i++) begin
                checks++;
                if (ram_model[i] !== img[i]) begin errors++; $display("FAIL rnd_ram[%0d] got %h want %h", i, ram_model[i], img[i]); end
            end
        end
    endtask

    task automatic test_strobe_held();
        logic we, run, err;
        logic [AW-1:0] a;
        logic [7:0] dat;
        logic [AW:0] cnt;
        int w0;
        start_load();
        w0 = wr_count;
        bus.byte_in = 8'hA5;
        bus.byte_strobe = 1'b1;
        repeat (20) tick();
        bus.byte_strobe = 1'b0;
        tick();
        checks += 3;
        if (wr_count - w0 !== 1)       begin errors++; $display("FAIL held_writes got %0d want 1", wr_count - w0); end
        if (bus.byte_count !== 5'd1)   begin errors++; $display("FAIL held_count got %0d want 1", bus.byte_count); end
        if (ram_model[0] !== 8'hA5)    begin errors++; $display("FAIL held_data got %h want a5", ram_model[0]); end
        // Strobe raised in IDLE and still high when LOAD is entered.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.byte_in = 8'h11;
        bus.byte_strobe = 1'b1;
        tick();
        tick();
        w0 = wr_count;
        start_load();
        repeat (5) tick();
        checks += 2;
        if (wr_count !== w0)         begin errors++; $display("FAIL entry_high_writes got %0d want 0", wr_count - w0); end
        if (bus.byte_count !== '0)   begin errors++; $display("FAIL entry_high_count got %0d want 0", bus.byte_count); end
        bus.byte_strobe = 1'b0;
        tick();
        strobe_byte(8'h3C, we, a, dat, cnt, run, err);
        checks += 2;
        if (we !== 1'b1 || a !== '0) begin errors++; $display("FAIL entry_rerise got we=%b addr=%0d want we=1 addr=0", we, a); end
        if (dat !== 8'h3C)           begin errors++; $display("FAIL entry_rerise_data got %h want 3c", dat); end
    endtask

    task automatic test_abort();
        logic we, run, err;
        logic [AW-1:0] a;
        logic [7:0] dat;
        logic [AW:0] cnt;
        int w0;
        start_load();
        for (int i = 0; i < 5; i++) strobe_byte(8'($urandom_range(0, 255)), we, a, dat, cnt, run, err);
        checks++;
        if (bus.byte_count !== 5'd5) begin errors++; $display("FAIL abort_pre_count got %0d want 5", bus.byte_count); end
        w0 = wr_count;
        bus.byte_in = 8'hEE;
        bus.load_req = 1'b1;
        bus.byte_strobe = 1'b1;
        tick();
        checks += 2;
        if (bus.ram_we !== 1'b0)   begin errors++; $display("FAIL abort_we got %b want 0", bus.ram_we); end
        if (bus.byte_count !== '0) begin errors++; $display("FAIL abort_count got %0d want 0", bus.byte_count); end
        bus.load_req = 1'b0;
        bus.byte_strobe = 1'b0;
        tick();
        checks++;
        if (wr_count !== w0) begin errors++; $display("FAIL abort_writes got %0d want 0", wr_count - w0); end
        strobe_byte(8'h5A, we, a, dat, cnt, run, err);
        checks += 2;
        if (we !== 1'b1 || a !== '0) begin errors++; $display("FAIL abort_next got we=%b addr=%0d want we=1 addr=0", we, a); end
        if (cnt !== 5'd1)            begin errors++; $display("FAIL abort_next_count got %0d want 1", cnt); end
    endtask

    task automatic test_run_reset();
        logic we, run, err;
        logic [AW-1:0] a;
        logic [7:0] dat;
        logic [AW:0] cnt;
        logic [7:0] d;
        int sum, w0;
        start_load();
        sum = 0;
        for (int i = 0; i < RB; i++) begin
            d = 8'($urandom_range(0, 255));
            sum = (sum + d) % 256;
            strobe_byte(d, we, a, dat, cnt, run, err);
        end
`ifdef LOADER_CHECKSUM_EN
        strobe_byte(8'((256 - sum) % 256), we, a, dat, cnt, run, err);
`endif
        w0 = wr_count;
        strobe_byte(8'h77, we, a, dat, cnt, run, err);
        strobe_byte(8'h78, we, a, dat, cnt, run, err);
        checks += 3;
        if (bus.cpu_run !== 1'b1)        begin errors++; $display("FAIL rr_run got %b want 1", bus.cpu_run); end
        if (wr_count !== w0)             begin errors++; $display("FAIL rr_sat_writes got %0d want 0", wr_count - w0); end
        if (bus.byte_count !== 5'd16)    begin errors++; $display("FAIL rr_sat_count got %0d want 16", bus.byte_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks += 6;
        if (bus.cpu_run !== 1'b0)    begin errors++; $display("FAIL rr_cpu_run got %b want 0", bus.cpu_run); end
        if (bus.byte_ready !== 1'b0) begin errors++; $display("FAIL rr_byte_ready got %b want 0", bus.byte_ready); end
        if (bus.ram_we !== 1'b0)     begin errors++; $display("FAIL rr_ram_we got %b want 0", bus.ram_we); end
        if (bus.ram_addr !== '0)     begin errors++; $display("FAIL rr_ram_addr got %h want 0", bus.ram_addr); end
        if (bus.ram_data !== '0)     begin errors++; $display("FAIL rr_ram_data got %h want 0", bus.ram_data); end
        if (bus.byte_count !== '0)   begin errors++; $display("FAIL rr_byte_count got %0d want 0", bus.byte_count); end
        w0 = wr_count;
        for (int i = 0; i < 3; i++) strobe_byte(8'(i + 1), we, a, dat, cnt, run, err);
        checks += 2;
        if (wr_count !== w0)      begin errors++; $display("FAIL rr_idle_writes got %0d want 0", wr_count - w0); end
        if (bus.cpu_run !== 1'b0) begin errors++; $display("FAIL rr_idle_run got %b want 0", bus.cpu_run); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        wr_count = 0;
        rst = 1'b1;
        bus.load_req = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_strobe = 1'b0;
        for (int i = 0; i < RB; i++) ram_model[i] = 8'h00;
        test_reset();
        test_sequential();
        test_checksum();
        test_random();
        test_strobe_held();
        test_abort();
        test_run_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
